// File: rtl/cpu_pkg.sv
// cpu_pkg: shared constants for the fetch/issue front end.
//   - opcode encodings (instr[15:12])
//   - branch condition encodings (instr[11:9])
//   - fetch FSM state enum
//   - branch offset helper for B (sign-extended word offset)
package cpu_pkg;

    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_ADD = 4'h1;
    localparam logic [3:0] OP_SUB = 4'h2;
    localparam logic [3:0] OP_AND = 4'h3;
    localparam logic [3:0] OP_OR  = 4'h4;
    localparam logic [3:0] OP_XOR = 4'h5;
    localparam logic [3:0] OP_NOT = 4'h6;
    localparam logic [3:0] OP_SHL = 4'h7;
    localparam logic [3:0] OP_SHR = 4'h8;
    localparam logic [3:0] OP_LDI = 4'h9;
    localparam logic [3:0] OP_LD  = 4'hA;
    localparam logic [3:0] OP_ST  = 4'hB;
    localparam logic [3:0] OP_B   = 4'hC;
    localparam logic [3:0] OP_BR  = 4'hD;
    localparam logic [3:0] OP_PCS = 4'hE;
    localparam logic [3:0] OP_HLT = 4'hF;

    localparam logic [2:0] CC_NE = 3'b000;
    localparam logic [2:0] CC_EQ = 3'b001;
    localparam logic [2:0] CC_GT = 3'b010;
    localparam logic [2:0] CC_LT = 3'b011;
    localparam logic [2:0] CC_GE = 3'b100;
    localparam logic [2:0] CC_LE = 3'b101;
    localparam logic [2:0] CC_VS = 3'b110;
    localparam logic [2:0] CC_AL = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FETCH  = 2'd1,
        ST_ISSUE  = 2'd2,
        ST_HALTED = 2'd3
    } fetch_state_t;

    // 9-bit word offset -> 16-bit byte offset
    function automatic logic [15:0] branch_offset(input logic [8:0] imm);
        return {{6{imm[8]}}, imm, 1'b0};
    endfunction

endpackage

// File: rtl/branch_cond.sv
// branch_cond: combinational branch condition evaluator.
// Ports:
//   ccc   - condition code from instr[11:9]
//   flags - registered {Z,V,N}
//   taken - condition is true
module branch_cond
    import cpu_pkg::*;
(
    input  logic [2:0] ccc,
    input  logic [2:0] flags,
    output logic       taken
);

    logic z;
    logic v;
    logic n;

    assign z = flags[2];
    assign v = flags[1];
    assign n = flags[0];

    always_comb begin
        taken = 1'b0;
        case (ccc)
            CC_NE: taken = ~z;
            CC_EQ: taken = z;
            CC_GT: taken = ~z & ~n;
            CC_LT: taken = n;
            CC_GE: taken = z | (~z & ~n);
            CC_LE: taken = n | z;
            CC_VS: taken = v;
            CC_AL: taken = 1'b1;
            default: taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch/issue sequencer with PC, instruction
// register, condition flags and B/BR/HLT handling.
// Ports:
//   clk, rst_n               - clock, async active-low reset
//   imem_req/addr/rdy/data   - instruction memory read handshake
//   instr, instr_valid       - issued instruction (one-cycle ISSUE)
//   pc_plus2                 - PC+2 of the issued instruction
//   jump, branch, br_target  - decoder controls and BR target
//   flags_in, flags_we       - ALU flags {Z,V,N} and write enables
//   halted                   - HLT retired, core stopped
//
// state   | meaning
// --------+---------------------------------------------------
// IDLE    | one dead cycle after reset release
// FETCH   | imem_req high, waiting for imem_rdy
// ISSUE   | instr valid for one cycle, PC update chosen here
// HALTED  | HLT retired; terminal until reset
module fetch_unit
    import cpu_pkg::*;
#(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic        imem_rdy,
    input  logic [15:0] imem_data,
    output logic [15:0] instr,
    output logic        instr_valid,
    output logic [15:0] pc_plus2,
    input  logic        jump,
    input  logic        branch,
    input  logic [15:0] br_target,
    input  logic [2:0]  flags_in,
    input  logic [2:0]  flags_we,
    output logic        halted
);

    fetch_state_t state;
    fetch_state_t state_nxt;
    logic [15:0]  pc;
    logic [15:0]  pc_nxt;
    logic [15:0]  ir;
    logic [15:0]  ir_nxt;
    logic [2:0]   flags;
    logic [3:0]   opcode;
    logic         cond_true;

    assign opcode = ir[15:12];

    branch_cond u_branch_cond (
        .ccc   (ir[11:9]),
        .flags (flags),
        .taken (cond_true)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            pc    <= RESET_PC;
            ir    <= 16'h0000;
            flags <= 3'b000;
        end else begin
            state <= state_nxt;
            pc    <= pc_nxt;
            ir    <= ir_nxt;
            // flags_we only counts while an instruction is executing
            if (state == ST_ISSUE) begin
                flags <= (flags & ~flags_we) | (flags_in & flags_we);
            end
        end
    end

    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        ir_nxt    = ir;
        case (state)
            ST_IDLE: begin
                state_nxt = ST_FETCH;
            end
            ST_FETCH: begin
                if (imem_rdy) begin
                    ir_nxt    = imem_data;
                    state_nxt = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (opcode == OP_HLT) begin
                    state_nxt = ST_HALTED;
                end else begin
                    state_nxt = ST_FETCH;
                    pc_nxt    = pc_plus2;
                    // cond_true reads the flag register, so a same-cycle
                    // flag write cannot affect this decision
                    if (jump && branch && cond_true) begin
                        if (opcode == OP_B) begin
                            pc_nxt = pc_plus2 + branch_offset(ir[8:0]);
                        end else if (opcode == OP_BR) begin
                            pc_nxt = br_target;
                        end
                    end
                end
            end
            ST_HALTED: begin
                state_nxt = ST_HALTED;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    assign imem_req    = (state == ST_FETCH);
    assign imem_addr   = pc;
    assign instr       = ir;
    assign instr_valid = (state == ST_ISSUE);
    assign pc_plus2    = pc + 16'd2;
    assign halted      = (state == ST_HALTED);

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

    logic        clk;
    logic        rst_n;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_rdy;
    logic [15:0] imem_data;
    logic [15:0] instr;
    logic        instr_valid;
    logic [15:0] pc_plus2;
    logic        jump;
    logic        branch;
    logic [15:0] br_target;
    logic [2:0]  flags_in;
    logic [2:0]  flags_we;
    logic        halted;

    logic [15:0] mem [0:32767];

    logic [2:0]  bc_ccc;
    logic [2:0]  bc_flags;
    logic        bc_taken;

    int total;
    int bad;

    typedef struct packed {
        logic        rdy;
        logic        exp_req;
        logic [15:0] exp_addr;
        logic        exp_valid;
        logic [15:0] exp_instr;
    } vec_t;

    vec_t vecs [10];

    fetch_unit #(.RESET_PC(16'h0000)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_rdy    (imem_rdy),
        .imem_data   (imem_data),
        .instr       (instr),
        .instr_valid (instr_valid),
        .pc_plus2    (pc_plus2),
        .jump        (jump),
        .branch      (branch),
        .br_target   (br_target),
        .flags_in    (flags_in),
        .flags_we    (flags_we),
        .halted      (halted)
    );

    branch_cond u_bc (
        .ccc   (bc_ccc),
        .flags (bc_flags),
        .taken (bc_taken)
    );

    assign imem_data = mem[imem_addr[15:1]];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Run to the next ISSUE, check it is at pc, then drive the decoder
    // controls for that issue cycle. noise is driven on flags_we/flags_in
    // during the preceding FETCH cycle(s) and must have no effect.
    task automatic issue(input string nm, input logic [15:0] pc, input logic jb,
                         input logic [15:0] tgt, input logic [2:0] fin,
                         input logic [2:0] fwe, input logic [2:0] noise);
        int n;
        n = 0;
        imem_rdy = 1'b1;
        jump = 1'b0;
        branch = 1'b0;
        flags_we = noise;
        flags_in = noise;
        while (!instr_valid && n < 20) begin
            step();
            n++;
        end
        chk({nm, "_valid"}, {15'd0, instr_valid}, 16'd1);
        chk({nm, "_addr"}, imem_addr, pc);
        chk({nm, "_instr"}, instr, mem[pc[15:1]]);
        chk({nm, "_pc2"}, pc_plus2, pc + 16'd2);
        jump = jb;
        branch = jb;
        br_target = tgt;
        flags_in = fin;
        flags_we = fwe;
        step();
        jump = 1'b0;
        branch = 1'b0;
        flags_we = 3'b000;
        flags_in = 3'b000;
    endtask

    initial begin
        logic exp_t;
        total = 0;
        bad = 0;
        rst_n = 1'b0;
        imem_rdy = 1'b1;
        jump = 1'b0;
        branch = 1'b0;
        br_target = 16'h0000;
        flags_in = 3'b000;
        flags_we = 3'b000;
        for (int i = 0; i < 32768; i++) mem[i] = 16'h0000;
        mem[16'h0000 >> 1] = 16'h1234;
        mem[16'h0002 >> 1] = 16'h2345;
        mem[16'h0004 >> 1] = 16'h3456;
        mem[16'h0006 >> 1] = 16'hDE00;  // BR always
        mem[16'h0008 >> 1] = 16'hF000;  // HLT
        mem[16'h0010 >> 1] = 16'hCE02;  // B always, +2
        mem[16'h0018 >> 1] = 16'h1000;  // non-branch with jump/branch
        mem[16'h0020 >> 1] = 16'hC3FF;  // B EQ, -1
        mem[16'h0022 >> 1] = 16'h1000;
        mem[16'h0024 >> 1] = 16'hDE00;  // BR always

        vecs[0] = '{1'b1, 1'b1, 16'h0000, 1'b0, 16'h0000};
        vecs[1] = '{1'b1, 1'b0, 16'h0000, 1'b1, 16'h1234};
        vecs[2] = '{1'b1, 1'b1, 16'h0002, 1'b0, 16'h0000};
        vecs[3] = '{1'b1, 1'b0, 16'h0002, 1'b1, 16'h2345};
        vecs[4] = '{1'b0, 1'b1, 16'h0004, 1'b0, 16'h0000};
        vecs[5] = '{1'b0, 1'b1, 16'h0004, 1'b0, 16'h0000};
        vecs[6] = '{1'b0, 1'b1, 16'h0004, 1'b0, 16'h0000};
        vecs[7] = '{1'b0, 1'b1, 16'h0004, 1'b0, 16'h0000};
        vecs[8] = '{1'b1, 1'b0, 16'h0004, 1'b1, 16'h3456};
        vecs[9] = '{1'b0, 1'b1, 16'h0006, 1'b0, 16'h0000};

        // condition evaluator, all ccc x flag combinations
        for (int c = 0; c < 8; c++) begin
            for (int f = 0; f < 8; f++) begin
                bc_ccc = 3'(c);
                bc_flags = 3'(f);
                case (c)
                    0: exp_t = !bc_flags[2];
                    1: exp_t = bc_flags[2];
                    2: exp_t = !bc_flags[2] && !bc_flags[0];
                    3: exp_t = bc_flags[0];
                    4: exp_t = bc_flags[2] || (!bc_flags[2] && !bc_flags[0]);
                    5: exp_t = bc_flags[0] || bc_flags[2];
                    6: exp_t = bc_flags[1];
                    default: exp_t = 1'b1;
                endcase
                #1;
                chk($sformatf("cond_c%0d_f%0d", c, f), {15'd0, bc_taken}, {15'd0, exp_t});
            end
        end

        // reset state
        step();
        step();
        chk("rst_req", {15'd0, imem_req}, 16'd0);
        chk("rst_addr", imem_addr, 16'h0000);
        chk("rst_pc2", pc_plus2, 16'h0002);
        chk("rst_instr", instr, 16'h0000);
        chk("rst_valid", {15'd0, instr_valid}, 16'd0);
        chk("rst_halted", {15'd0, halted}, 16'd0);
        rst_n = 1'b1;

        // sequential fetch then a wait state at 0x0004
        for (int i = 0; i < 10; i++) begin
            imem_rdy = vecs[i].rdy;
            step();
            chk($sformatf("v%0d_req", i), {15'd0, imem_req}, {15'd0, vecs[i].exp_req});
            chk($sformatf("v%0d_addr", i), imem_addr, vecs[i].exp_addr);
            chk($sformatf("v%0d_valid", i), {15'd0, instr_valid}, {15'd0, vecs[i].exp_valid});
            if (vecs[i].exp_valid) begin
                chk($sformatf("v%0d_instr", i), instr, vecs[i].exp_instr);
                chk($sformatf("v%0d_pc2", i), pc_plus2, vecs[i].exp_addr + 16'd2);
            end
        end

        // program walk through B, EQ branch, BR wrap and HLT
        issue("br_06",    16'h0006, 1'b1, 16'h0010, 3'b000, 3'b000, 3'b000);
        issue("b_10",     16'h0010, 1'b1, 16'h0000, 3'b000, 3'b000, 3'b000);
        issue("nop_16",   16'h0016, 1'b0, 16'h0000, 3'b000, 3'b000, 3'b000);
        issue("nonbr_18", 16'h0018, 1'b1, 16'h0040, 3'b000, 3'b000, 3'b000);
        issue("nop_1a",   16'h001A, 1'b0, 16'h0000, 3'b000, 3'b000, 3'b000);
        issue("nop_1c",   16'h001C, 1'b0, 16'h0000, 3'b000, 3'b000, 3'b000);
        issue("nop_1e",   16'h001E, 1'b0, 16'h0000, 3'b000, 3'b000, 3'b000);
        issue("eq_nt",    16'h0020, 1'b1, 16'h0000, 3'b000, 3'b000, 3'b111);
        issue("setz_22",  16'h0022, 1'b0, 16'h0000, 3'b100, 3'b100, 3'b000);
        issue("br_24a",   16'h0024, 1'b1, 16'h0020, 3'b000, 3'b000, 3'b000);
        issue("eq_t",     16'h0020, 1'b1, 16'h0000, 3'b000, 3'b100, 3'b000);
        issue("eq_nt2",   16'h0020, 1'b1, 16'h0000, 3'b000, 3'b000, 3'b000);
        issue("nop_22",   16'h0022, 1'b0, 16'h0000, 3'b000, 3'b000, 3'b000);
        issue("br_24b",   16'h0024, 1'b1, 16'hFFFE, 3'b000, 3'b000, 3'b000);
        issue("nop_fffe", 16'hFFFE, 1'b0, 16'h0000, 3'b000, 3'b000, 3'b000);
        issue("wrap_00",  16'h0000, 1'b0, 16'h0000, 3'b000, 3'b000, 3'b000);
        issue("seq_02",   16'h0002, 1'b0, 16'h0000, 3'b000, 3'b000, 3'b000);
        issue("seq_04",   16'h0004, 1'b0, 16'h0000, 3'b000, 3'b000, 3'b000);
        issue("br_06b",   16'h0006, 1'b1, 16'h0008, 3'b000, 3'b000, 3'b000);
        issue("hlt_08",   16'h0008, 1'b0, 16'h0000, 3'b000, 3'b000, 3'b000);

        chk("hlt_halted", {15'd0, halted}, 16'd1);
        chk("hlt_req", {15'd0, imem_req}, 16'd0);
        chk("hlt_valid", {15'd0, instr_valid}, 16'd0);
        for (int i = 0; i < 10; i++) begin
            jump = 1'b1;
            branch = 1'b1;
            flags_we = 3'b111;
            flags_in = 3'b111;
            imem_rdy = 1'b1;
            step();
            chk($sformatf("halt%0d_req", i), {15'd0, imem_req}, 16'd0);
            chk($sformatf("halt%0d_halted", i), {15'd0, halted}, 16'd1);
            chk($sformatf("halt%0d_addr", i), imem_addr, 16'h0008);
        end
        jump = 1'b0;
        branch = 1'b0;
        flags_we = 3'b000;
        flags_in = 3'b000;

        // restart from halt
        rst_n = 1'b0;
        #1;
        chk("rst2_addr", imem_addr, 16'h0000);
        chk("rst2_halted", {15'd0, halted}, 16'd0);
        chk("rst2_pc2", pc_plus2, 16'h0002);
        step();
        rst_n = 1'b1;
        step();
        chk("rst2_req", {15'd0, imem_req}, 16'd1);
        chk("rst2_fetch", imem_addr, 16'h0000);

        // async reset in FETCH drops imem_req before any edge
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_req", {15'd0, imem_req}, 16'd0);
        step();
        chk("async_valid", {15'd0, instr_valid}, 16'd0);
        chk("async_instr", instr, 16'h0000);
        rst_n = 1'b1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 The block SHALL have the parameter RESET_PC, default 16'h0000, which is the first fetch address after reset.
REQ-002 The block SHALL have the port clk, input, 1 bit: single clock; all state updates on the rising edge.
REQ-003 The block SHALL have the port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have the port imem_req, output, 1 bit: instruction-memory read request.
REQ-005 The block SHALL have the port imem_addr, output, 16 bits: byte address of the fetch, equal to the PC.
REQ-006 The block SHALL have the port imem_rdy, input, 1 bit: the memory has driven imem_data for the current request.
REQ-007 The block SHALL have the port imem_data, input, 16 bits: the fetched instruction word.
REQ-008 The block SHALL have the port instr, output, 16 bits: the issued instruction, fed to the control decoder.
REQ-009 The block SHALL have the port instr_valid, output, 1 bit: instr is executing this cycle.
REQ-010 The block SHALL have the port pc_plus2, output, 16 bits: PC+2 of the issued instruction, used by PCS.
REQ-011 The block SHALL have the port jump, input, 1 bit: the decoder's Jump signal for instr.
REQ-012 The block SHALL have the port branch, input, 1 bit: the decoder's Branch signal for instr.
REQ-013 The block SHALL have the port br_target, input, 16 bits: the rs register value, used as the BR target.
REQ-014 The block SHALL have the port flags_in, input, 3 bits: {Z,V,N} from the ALU.
REQ-015 The block SHALL have the port flags_we, input, 3 bits: per-flag write enables {Z,V,N}.
REQ-016 The block SHALL have the port halted, output, 1 bit: HLT has retired; the core is stopped.

Function
REQ-017 The FSM SHALL have the states IDLE, FETCH, ISSUE and HALTED.
REQ-018 IDLE SHALL go to FETCH unconditionally; it provides one dead cycle after reset release.
REQ-019 In FETCH, imem_req SHALL be 1 and imem_addr SHALL equal PC; the block SHALL stay in FETCH while imem_rdy=0.
REQ-020 When imem_rdy=1 in FETCH, imem_data SHALL be latched into the instruction register and the FSM SHALL go to ISSUE.
REQ-021 ISSUE SHALL last exactly one cycle, with instr_valid=1, instr=latched word and pc_plus2=PC+2 (mod 2^16).
REQ-022 In ISSUE with opcode instr[15:12]=4'hF (HLT), PC SHALL hold and the FSM SHALL go to HALTED.
REQ-023 In ISSUE with jump&branch=1 and the condition true, PC SHALL load the target: B (opcode 4'hC) = PC+2 + (sext(instr[8:0])<<1); BR (4'hD) = br_target.
REQ-024 In all other ISSUE cases, PC SHALL load PC+2, and the FSM SHALL then go to FETCH.
REQ-025 The condition ccc=instr[11:9] SHALL be evaluated as: 000 Z=0; 001 Z=1; 010 Z=0&N=0; 011 N=1; 100 Z=1|(Z=0&N=0); 101 N=1|Z=1; 110 V=1; 111 always.
REQ-026 The condition SHALL use the registered flags before any same-cycle update.
REQ-027 Each flag SHALL update from flags_in only when instr_valid=1 and its flags_we bit=1; flags_we outside ISSUE SHALL be ignored.
REQ-028 All address arithmetic SHALL be 16-bit and wrap modulo 2^16; bit 0 of a target SHALL be passed through unmodified.
REQ-029 imem_rdy outside FETCH SHALL be ignored.
REQ-030 imem_req SHALL be 0 in IDLE, ISSUE and HALTED.
REQ-031 HALTED SHALL be terminal until reset, with halted=1, imem_req=0 and instr_valid=0.
REQ-032 In HALTED, jump, branch and flags_we SHALL be ignored.
REQ-033 jump/branch asserted with a non-branch opcode SHALL be treated as not taken.

Reset
REQ-034 While rst_n=0, the block SHALL hold PC=RESET_PC, state=IDLE, flags=3'b000 and instruction register=16'h0000.
REQ-035 While rst_n=0, all outputs SHALL be 0 except imem_addr=RESET_PC and pc_plus2=RESET_PC+2.
REQ-036 Reset assertion during FETCH SHALL drop imem_req immediately (asynchronously); any outstanding imem_rdy SHALL be discarded.

Structure
REQ-037 A shared package cpu_pkg SHALL hold the opcode constants (4'h0-4'hF), the ccc encodings and the FSM state enum.
REQ-038 The condition evaluator SHALL be one combinational sub-module, branch_cond (inputs ccc and flags; output taken).

Verification
REQ-039 The bench SHALL check reset with RESET_PC=0, imem_rdy tied to 1: fetches at 0,2,4 and instr_valid every 2nd cycle after the IDLE cycle.
REQ-040 The bench SHALL check a wait state: imem_rdy=0 for 3 cycles, so FETCH is held 4 cycles with stable imem_addr, then one ISSUE.
REQ-041 The bench SHALL check B at PC=0x0010, instr=16'hCE02 (ccc=111, imm=+2): the next fetch is at 0x0016.
REQ-042 The bench SHALL check an EQ branch with Z=0: B at 0x0020, instr 16'hC3FF (imm=-1) is not taken (next 0x0022); after Z is set to 1 it is taken (target 0x0020).
REQ-043 The bench SHALL check BR with br_target=0xFFFE (ccc=111), then a fall-through fetch at 0x0000 (wrap).
REQ-044 The bench SHALL check HLT 16'hF000 at PC=0x0008: halted=1, imem_req stays 0 for 10 cycles, and rst_n low-then-high restarts the fetch at RESET_PC.
